// File: rtl/aes_iter_multikey_if.sv
// Handshake bundle for aes_iter_multikey.
// Ports: key load (key_valid/key_ready/key_len/key), plaintext in (in_valid/in_ready/in_data),
//        ciphertext out (out_valid/out_ready/out_data), status (busy/key_ok/key_err).
// master: key/plaintext source and ciphertext sink; slave: the AES core.
interface aes_iter_multikey_if #(
   parameter int KEY_W = 256
) ();
   logic             key_valid;
   logic             key_ready;
   logic [1:0]       key_len;
   logic [KEY_W-1:0] key;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             busy;
   logic             key_ok;
   logic             key_err;

   modport master (
      output key_valid, key_len, key, in_valid, in_data, out_ready,
      input  key_ready, in_ready, out_valid, out_data, busy, key_ok, key_err
   );

   modport slave (
      input  key_valid, key_len, key, in_valid, in_data, out_ready,
      output key_ready, in_ready, out_valid, out_data, busy, key_ok, key_err
   );
endinterface

// File: rtl/aes_iter_multikey.sv
// Iterative AES-128/192/256 encryptor: one round per cycle, key expanded once into a word store.
// Ports: clk, rst (async, active high); bus (slave) carries key load, plaintext, ciphertext, status.
module aes_iter_multikey #(
   parameter int KEY_W        = 256,
   parameter bit RK_INIT_ZERO = 1'b1
) (
   input logic                clk,
   input logic                rst,
   aes_iter_multikey_if.slave bus
);
   localparam int RKW = 4 * (KEY_W / 32 + 7);
   localparam int KWN = KEY_W / 32;

   typedef enum logic [1:0] {IDLE, EXPAND, ROUND, HOLD} state_e;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p, r, s;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
            ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]};
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] s4(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // SubBytes + ShiftRows; byte k = row k%4, column k/4
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] =
               sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   function automatic logic [127:0] one_round(
      input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      t = sub_shift(s);
      return {mix_col(t[127:96]), mix_col(t[95:64]),
              mix_col(t[63:32]), mix_col(t[31:0])} ^ k;
   endfunction

   function automatic logic [127:0] final_round(
      input logic [127:0] s, input logic [127:0] k);
      return sub_shift(s) ^ k;
   endfunction

   state_e       state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] out_q, out_d;
   logic         ov_q, ov_d;
   logic         kok_q, kok_d;
   logic         kerr_q, kerr_d;
   logic [3:0]   nk_q, nk_d;
   logic [5:0]   wcnt_q, wcnt_d;
   logic [2:0]   kc_q, kc_d;
   logic         ph_q, ph_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [31:0]  tmp_q, tmp_d;
   logic [3:0]   rnd_q, rnd_d;

   logic [31:0]  rk_mem [RKW];
   logic         ld_we, ex_we;
   logic [31:0]  ex_wd;

   logic [3:0]   nk_new;
   logic [3:0]   nr;
   logic         key_bad;
   logic [5:0]   rk_base;
   logic [5:0]   w_last;
   logic [127:0] rk_0, rk_cur;
   logic [31:0]  w_prev, w_back;

   always_comb begin
      unique case (bus.key_len)
         2'd0:    nk_new = 4'd4;
         2'd1:    nk_new = 4'd6;
         default: nk_new = 4'd8;
      endcase
   end

   assign key_bad = (bus.key_len == 2'd3) || (32 * int'(nk_new) > KEY_W);
   assign nr      = nk_q + 4'd6;
   assign rk_base = {rnd_q, 2'b00};
   assign w_last  = {nk_q, 2'b00} + 6'd27;
   assign rk_0    = {rk_mem[0], rk_mem[1], rk_mem[2], rk_mem[3]};
   assign rk_cur  = {rk_mem[rk_base], rk_mem[rk_base + 6'd1],
                     rk_mem[rk_base + 6'd2], rk_mem[rk_base + 6'd3]};
   assign w_prev  = rk_mem[wcnt_q - 6'd1];
   assign w_back  = rk_mem[wcnt_q - {2'b00, nk_q}];
   assign ex_wd   = w_back ^ tmp_q;

   assign bus.key_ready = (state_q == IDLE);
   assign bus.in_ready  = (state_q == IDLE) & kok_q & ~bus.key_valid;
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = ov_q;
   assign bus.out_data  = out_q;
   assign bus.key_ok    = kok_q;
   assign bus.key_err   = kerr_q;

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      out_d   = out_q;
      ov_d    = ov_q;
      kok_d   = kok_q;
      kerr_d  = kerr_q;
      nk_d    = nk_q;
      wcnt_d  = wcnt_q;
      kc_d    = kc_q;
      ph_d    = ph_q;
      rcon_d  = rcon_q;
      tmp_d   = tmp_q;
      rnd_d   = rnd_q;
      ld_we   = 1'b0;
      ex_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.key_valid) begin
               kok_d = 1'b0;
               if (key_bad) begin
                  kerr_d = 1'b1;
               end else begin
                  kerr_d  = 1'b0;
                  ld_we   = 1'b1;
                  nk_d    = nk_new;
                  wcnt_d  = {2'b00, nk_new};
                  kc_d    = 3'd0;
                  ph_d    = 1'b0;
                  rcon_d  = 8'h01;
                  state_d = EXPAND;
               end
            end else if (bus.in_valid && kok_q) begin
               blk_d   = bus.in_data ^ rk_0;
               rnd_d   = 4'd1;
               state_d = ROUND;
            end
         end
         EXPAND: begin
            // Phase 0 registers the (S4-transformed) temp word, phase 1 writes w[i]
            if (!ph_q) begin
               ph_d = 1'b1;
               if (kc_q == 3'd0) begin
                  tmp_d  = s4({w_prev[23:0], w_prev[31:24]})
                           ^ {rcon_q, 24'h0};
                  rcon_d = xt(rcon_q);
               end else if (nk_q == 4'd8 && kc_q == 3'd4) begin
                  tmp_d = s4(w_prev);
               end else begin
                  tmp_d = w_prev;
               end
            end else begin
               ph_d   = 1'b0;
               ex_we  = 1'b1;
               kc_d   = ({1'b0, kc_q} == nk_q - 4'd1) ? 3'd0 : kc_q + 3'd1;
               wcnt_d = wcnt_q + 6'd1;
               if (wcnt_q == w_last) begin
                  kok_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         ROUND: begin
            if (rnd_q == nr) begin
               out_d   = final_round(blk_q, rk_cur);
               ov_d    = 1'b1;
               state_d = HOLD;
            end else begin
               blk_d = one_round(blk_q, rk_cur);
               rnd_d = rnd_q + 4'd1;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q   <= '0;
         out_q   <= '0;
         ov_q    <= 1'b0;
         kok_q   <= 1'b0;
         kerr_q  <= 1'b0;
         nk_q    <= '0;
         wcnt_q  <= '0;
         kc_q    <= '0;
         ph_q    <= 1'b0;
         rcon_q  <= '0;
         tmp_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         kok_q   <= kok_d;
         kerr_q  <= kerr_d;
         nk_q    <= nk_d;
         wcnt_q  <= wcnt_d;
         kc_q    <= kc_d;
         ph_q    <= ph_d;
         rcon_q  <= rcon_d;
         tmp_q   <= tmp_d;
         rnd_q   <= rnd_d;
      end
   end

   // Round-key store: key words on load, one expanded word per phase-1 cycle
   generate
      if (RK_INIT_ZERO) begin : g_rk_rst
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int j = 0; j < RKW; j++) rk_mem[j] <= '0;
            end else begin
               if (ld_we) begin
                  for (int j = 0; j < KWN; j++) begin
                     if (j < int'(nk_new))
                        rk_mem[j] <= bus.key[KEY_W-1-32*j -: 32];
                  end
               end
               if (ex_we) rk_mem[wcnt_q] <= ex_wd;
            end
         end
      end else begin : g_rk_nrst
         always_ff @(posedge clk) begin
            if (ld_we) begin
               for (int j = 0; j < KWN; j++) begin
                  if (j < int'(nk_new))
                     rk_mem[j] <= bus.key[KEY_W-1-32*j -: 32];
               end
            end
            if (ex_we) rk_mem[wcnt_q] <= ex_wd;
         end
      end
   endgenerate
endmodule

// File: tb/tb_aes_iter_multikey.sv
// Self-checking bench for aes_iter_multikey: FIPS-197 vectors plus random keys/blocks
// against a byte-level AES reference model.
module tb_aes_iter_multikey;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_iter_multikey_if #(.KEY_W(256)) bus ();

   aes_iter_multikey #(.KEY_W(256), .RK_INIT_ZERO(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp;
   int n_err;
   logic [7:0] sb [256];

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // S-box table from the generator walk: p steps by *3, q by /3
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'b0000};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
               ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   function automatic logic [7:0] x2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rsub(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [127:0] ref_enc(input logic [255:0] key,
                                            input int nk,
                                            input logic [127:0] pt);
      logic [31:0] w [60];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [31:0] tw;
      logic [7:0] rc;
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] ct;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tw = w[i-1];
         if (i % nk == 0) begin
            tw = rsub({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
            rc = x2(rc);
         end else if (nk == 8 && i % nk == 4) begin
            tw = rsub(tw);
         end
         w[i] = w[i-nk] ^ tw;
      end
      for (int k = 0; k < 16; k++)
         s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int k = 0; k < 16; k++)
            t[k] = sb[s[4*(((k/4) + (k%4)) % 4) + (k%4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < nr) begin
               s[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
               s[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int k = 0; k < 16; k++)
            s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
      end
      ct = '0;
      for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
      return ct;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int exp_klat(input logic [1:0] len);
      return (len == 2'd0) ? 80 : (len == 2'd1) ? 92 : 104;
   endfunction

   // Called #1 after a clock edge with the core idle
   task automatic load_key(input logic [1:0] len, input logic [255:0] k);
      int n;
      chk("key_ready", bus.key_ready, 1);
      bus.key_valid = 1'b1;
      bus.key_len   = len;
      bus.key       = k;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      bus.key       = rnd256();
      chk("exp_busy", bus.busy, 1);
      chk("exp_kok0", bus.key_ok, 0);
      n = 0;
      while (!bus.key_ok && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("key_lat", n, exp_klat(len));
      chk("key_err_clr", bus.key_err, 0);
   endtask

   // Latency counts the accept cycle as the first cycle
   task automatic encrypt(input logic [127:0] pt, input logic [127:0] ct,
                          input int nr, input int stall);
      int n;
      logic ok;
      chk("in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = pt;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = rnd256()[127:0];
      n = 1;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_lat", n, nr + 1);
      chk("ct", bus.out_data, ct);
      if (stall > 0) begin
         ok = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== ct || bus.in_ready)
               ok = 1'b0;
         end
         chk("hold_stable", ok, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("ov_drop", bus.out_valid, 0);
      chk("idle_after", bus.busy, 0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_kok"}, bus.key_ok, 0);
      chk({tag, "_ov"}, bus.out_valid, 0);
      chk({tag, "_od"}, bus.out_data, 0);
      chk({tag, "_kerr"}, bus.key_err, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] k;
      logic [127:0] pt;
      logic [1:0]   len;
      int           nk;
      int           n;
      build_sbox();
      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_len   = 2'd0;
      bus.key       = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cleared("rst");
      chk("rst_inrdy", bus.in_ready, 0);
      chk("rst_krdy", bus.key_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Plaintext without a key is not taken
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("nokey_busy", bus.busy, 0);
      bus.in_valid = 1'b0;

      // FIPS-197 vectors, no reset between loads
      load_key(2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      encrypt(PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0);
      load_key(2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                      64'h0});
      encrypt(PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, 20);
      load_key(2'd2,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      encrypt(PT, 128'h8ea2b7ca516745bfeafc49904b496089, 14, 0);

      // Random keys of every size, unused low key bits left random
      for (int it = 0; it < 8; it++) begin
         len = 2'($urandom_range(0, 2));
         nk  = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
         k   = rnd256();
         load_key(len, k);
         for (int b = 0; b < 2; b++) begin
            pt = rnd256()[127:0];
            encrypt(pt, ref_enc(k, nk, pt), nk + 6, $urandom_range(0, 3));
         end
      end

      // Key and plaintext in the same cycle: key wins
      k  = rnd256();
      pt = rnd256()[127:0];
      bus.key_valid = 1'b1;
      bus.key_len   = 2'd0;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      bus.in_data   = pt;
      #1;
      chk("kin_inrdy", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      bus.in_valid  = 1'b0;
      chk("kin_busy", bus.busy, 1);
      chk("kin_kok", bus.key_ok, 0);
      n = 0;
      while (!bus.key_ok && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("kin_lat", n, 80);
      encrypt(pt, ref_enc(k, 4, pt), 10, 0);

      // Illegal key length
      bus.key_valid = 1'b1;
      bus.key_len   = 2'd3;
      bus.key       = rnd256();
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      chk("ill_err", bus.key_err, 1);
      chk("ill_kok", bus.key_ok, 0);
      chk("ill_busy", bus.busy, 0);
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ill_inrdy", bus.in_ready, 0);
      chk("ill_noin", bus.busy, 0);
      bus.in_valid = 1'b0;
      k = rnd256();
      load_key(2'd2, k);
      pt = rnd256()[127:0];
      encrypt(pt, ref_enc(k, 8, pt), 14, 0);

      // Reset in EXPAND cycle 40
      bus.key_valid = 1'b1;
      bus.key_len   = 2'd1;
      bus.key       = rnd256();
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_cleared("rstx");
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      k = rnd256();
      load_key(2'd1, k);
      pt = rnd256()[127:0];
      encrypt(pt, ref_enc(k, 6, pt), 12, 1);

      // Reset during round 5
      pt = rnd256()[127:0];
      bus.in_valid = 1'b1;
      bus.in_data  = pt;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_cleared("rstr");
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      k = rnd256();
      load_key(2'd0, k);
      encrypt(pt, ref_enc(k, 4, pt), 10, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
